// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encodings,
// port identifiers, default geometry and the request error check.
package dmem_pkg;

  localparam int ADDR_W_DEF    = 64;
  localparam int DATA_W_DEF    = 64;
  localparam int MEM_BYTES_DEF = 1024;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // A request is bad if it would run past the end of memory (any upper
  // address bit set counts) or, when checking is on, is not word aligned.
  function automatic logic addr_err(
    input logic [63:0] addr,
    input logic [63:0] last_legal,
    input logic [63:0] align_mask,
    input logic        align_chk
  );
    return (addr > last_legal) || (align_chk && ((addr & align_mask) != 64'd0));
  endfunction

  // One-hot response/grant vector for a single port id.
  function automatic logic [1:0] port_onehot(input logic id);
    return {id, ~id};
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way grant logic. A lone requester always wins; on a tie the grant
// goes to the port that was not served last (round-robin) or always to
// the CPU port (fixed priority).
module dmem_rr_arb
  import dmem_pkg::*;
#(
  parameter int ARB_RR = 1
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Tie-break between the two ports; single requests pass straight through.
  always_comb begin
    grant = 2'b00;
    if (valid[PORT_CPU] && valid[PORT_DMA]) begin
      if ((ARB_RR != 0) && (last_grant == PORT_CPU)) begin
        grant[PORT_DMA] = 1'b1;
      end else begin
        grant[PORT_CPU] = 1'b1;
      end
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the CPU load/store stage and
// the DMA/debug loader. One access is in flight at a time; the FSM drives
// the memory strobes, waits out the read latency and returns a tagged,
// single-cycle response to the port that owns the access.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ARB_RR    = 1,
  parameter int ALIGN_CHK = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req_valid,
  input  logic [1:0]        i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr0,
  input  logic [ADDR_W-1:0] i_req_addr1,
  input  logic [DATA_W-1:0] i_req_wdata0,
  input  logic [DATA_W-1:0] i_req_wdata1,
  output logic [1:0]        o_req_ready,
  output logic [1:0]        o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam int          BYTES      = DATA_W / 8;
  localparam logic [63:0] LAST_LEGAL = 64'(MEM_BYTES - BYTES);
  localparam logic [63:0] ALIGN_MASK = 64'(BYTES - 1);

  state_t            state_reg;
  logic              last_grant_reg;
  logic              req_id_reg;
  logic              req_we_reg;
  logic [1:0]        rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              rsp_err_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              mem_read_reg;
  logic              mem_write_reg;

  logic [1:0]        grant;
  logic              accept;
  logic              sel_id;
  logic              sel_we;
  logic              sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  dmem_rr_arb #(
    .ARB_RR (ARB_RR)
  ) u_arb (
    .valid      (i_req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  // Ready is combinational so the winner transfers in the same IDLE cycle.
  assign o_req_ready = (state_reg == ST_IDLE) ? grant : 2'b00;
  assign accept      = |(i_req_valid & o_req_ready);
  assign sel_id      = o_req_ready[PORT_DMA];
  assign sel_we      = i_req_we[sel_id];
  assign sel_addr    = sel_id ? i_req_addr1  : i_req_addr0;
  assign sel_wdata   = sel_id ? i_req_wdata1 : i_req_wdata0;
  assign sel_err     = addr_err(64'(sel_addr), LAST_LEGAL, ALIGN_MASK, ALIGN_CHK != 0);

  // Access sequencer: accept/latch, strobe memory, wait for read data, respond.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= PORT_DMA;
      req_id_reg     <= PORT_CPU;
      req_we_reg     <= 1'b0;
      rsp_valid_reg  <= 2'b00;
      rsp_rdata_reg  <= '0;
      rsp_err_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
    end else begin
      // Strobes and responses are single-cycle pulses unless set below.
      rsp_valid_reg <= 2'b00;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            req_id_reg     <= sel_id;
            req_we_reg     <= sel_we;
            last_grant_reg <= sel_id;
            if (sel_err) begin
              // Bad requests never touch memory; answer on the next cycle.
              state_reg     <= ST_RESP;
              rsp_valid_reg <= port_onehot(sel_id);
              rsp_err_reg   <= 1'b1;
            end else begin
              state_reg     <= ST_ACCESS;
              mem_addr_reg  <= sel_addr;
              mem_wdata_reg <= sel_wdata;
              mem_read_reg  <= ~sel_we;
              mem_write_reg <= sel_we;
            end
          end
        end
        ST_ACCESS: begin
          if (req_we_reg) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= port_onehot(req_id_reg);
          end else begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Memory presents the registered read result during this cycle.
          state_reg     <= ST_RESP;
          rsp_valid_reg <= port_onehot(req_id_reg);
          rsp_rdata_reg <= i_mem_rdata;
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_rdata = rsp_rdata_reg;
  assign o_rsp_err   = rsp_err_reg;
  assign o_mem_addr  = mem_addr_reg;
  assign o_mem_wdata = mem_wdata_reg;
  assign o_mem_read  = mem_read_reg;
  assign o_mem_write = mem_write_reg;
  assign o_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a byte-array reference model
// predicts grants, latencies and load data; a separate monitor pops the
// expectations whenever a response pulse appears.
module tb_dmem_port_arbiter;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } stim_t;

  typedef struct {
    int          port;
    logic [63:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_req_valid = 2'b00;
  logic [1:0]  i_req_we = 2'b00;
  logic [63:0] i_req_addr0 = '0, i_req_addr1 = '0;
  logic [63:0] i_req_wdata0 = '0, i_req_wdata1 = '0;
  logic [1:0]  o_req_ready, o_rsp_valid;
  logic [63:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
  logic        o_rsp_err, o_mem_read, o_mem_write, o_busy;
  logic [63:0] mem_rdata = '0;

  // Second instance with fixed priority, exercised only in its own phase.
  logic [1:0]  f_valid = 2'b00;
  logic [1:0]  f_we = 2'b00;
  logic [63:0] f_addr0 = 64'h40, f_addr1 = 64'h48;
  logic [63:0] f_wdata0 = '0, f_wdata1 = '0;
  logic [1:0]  f_ready, f_rsp_valid;
  logic [63:0] f_rsp_rdata, f_mem_addr, f_mem_wdata;
  logic        f_rsp_err, f_mem_read, f_mem_write, f_busy;
  logic [63:0] f_mem_rdata = '0;

  dmem_port_arbiter u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_we(i_req_we),
    .i_req_addr0(i_req_addr0), .i_req_addr1(i_req_addr1),
    .i_req_wdata0(i_req_wdata0), .i_req_wdata1(i_req_wdata1),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .i_mem_rdata(mem_rdata),
    .o_busy(o_busy)
  );

  dmem_port_arbiter #(.ARB_RR(0)) u_fix (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(f_valid), .i_req_we(f_we),
    .i_req_addr0(f_addr0), .i_req_addr1(f_addr1),
    .i_req_wdata0(f_wdata0), .i_req_wdata1(f_wdata1),
    .o_req_ready(f_ready), .o_rsp_valid(f_rsp_valid), .o_rsp_rdata(f_rsp_rdata),
    .o_rsp_err(f_rsp_err), .o_mem_addr(f_mem_addr), .o_mem_wdata(f_mem_wdata),
    .o_mem_read(f_mem_read), .o_mem_write(f_mem_write), .i_mem_rdata(f_mem_rdata),
    .o_busy(f_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pct = 100;
  stim_t q0[$];
  stim_t q1[$];
  exp_t  exp_q[$];
  int    rd_idx = 0;
  int    flush_idx = 0;
  int    acc_cnt0 = 0, acc_cnt1 = 0, acc_total = 0;
  logic [7:0]  ref_mem [0:1023];
  logic [63:0] mem_w [0:127];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input int last);
    if (v == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic stim_t rand_item();
    stim_t s;
    int sel;
    sel     = $urandom_range(15);
    s.we    = 1'($urandom_range(1));
    s.wdata = {$urandom, $urandom};
    case (sel)
      0:       s.addr = 64'($urandom_range(1023, 1017));
      1:       s.addr = 64'($urandom_range(127)) * 64'd8 + 64'($urandom_range(7, 1));
      2:       s.addr = {$urandom | 32'h1, 32'($urandom_range(127) * 8)};
      default: s.addr = 64'($urandom_range(127)) * 64'd8;
    endcase
    return s;
  endfunction

  function automatic stim_t mk(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    stim_t s;
    s.we = we; s.addr = addr; s.wdata = wdata;
    return s;
  endfunction

  // Environment memory: word array, read data registered one cycle after the strobe.
  initial begin
    for (int w = 0; w < 128; w++) begin
      mem_w[w] = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) ref_mem[w * 8 + b] = mem_w[w][8 * b +: 8];
    end
    forever begin
      @(posedge i_clk);
      if (o_mem_write) mem_w[o_mem_addr[9:3]] <= o_mem_wdata;
      if (o_mem_read) mem_rdata <= mem_w[o_mem_addr[9:3]];
    end
  end

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Stimulus driver: present the head of each port queue, hold until accepted.
  initial begin
    int seen0 = 0, seen1 = 0;
    stim_t s;
    forever begin
      @(posedge i_clk);
      #1;
      if (acc_cnt0 != seen0) begin seen0 = acc_cnt0; i_req_valid[0] = 1'b0; end
      if (acc_cnt1 != seen1) begin seen1 = acc_cnt1; i_req_valid[1] = 1'b0; end
      if (!i_req_valid[0] && q0.size() > 0 && $urandom_range(99) < pct) begin
        s = q0.pop_front();
        i_req_valid[0] = 1'b1; i_req_we[0] = s.we; i_req_addr0 = s.addr; i_req_wdata0 = s.wdata;
      end
      if (!i_req_valid[1] && q1.size() > 0 && $urandom_range(99) < pct) begin
        s = q1.pop_front();
        i_req_valid[1] = 1'b1; i_req_we[1] = s.we; i_req_addr1 = s.addr; i_req_wdata1 = s.wdata;
      end
    end
  end

  // Reference model: predicts ready/busy/strobes and queues expected responses.
  initial begin
    int last_port = 1;
    int next_free = 0;
    int st_cyc = -1;
    logic st_we = 1'b0;
    logic [63:0] st_addr = '0, st_wdata = '0;
    logic [1:0] hs;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        last_port = 1; next_free = cyc + 1; st_cyc = -1;
        flush_idx = exp_q.size();
        continue;
      end
      chk("busy", 64'(o_busy), 64'(cyc < next_free));
      if (i_req_valid != 2'b00 || o_req_ready != 2'b00)
        chk("req_ready", 64'(o_req_ready), 64'((cyc >= next_free) ? exp_grant(i_req_valid, last_port) : 2'b00));
      if (o_mem_read || o_mem_write || cyc == st_cyc) begin
        chk("mem_strobe", 64'({o_mem_read, o_mem_write}), 64'({cyc == st_cyc && !st_we, cyc == st_cyc && st_we}));
        if (cyc == st_cyc) chk("mem_addr", o_mem_addr, st_addr);
        if (cyc == st_cyc && st_we) chk("mem_wdata", o_mem_wdata, st_wdata);
      end
      hs = i_req_valid & o_req_ready;
      if (hs != 2'b00) begin
        exp_t e;
        logic [63:0] a, d;
        int lat;
        e.port = hs[0] ? 0 : 1;
        a = (e.port == 0) ? i_req_addr0 : i_req_addr1;
        d = (e.port == 0) ? i_req_wdata0 : i_req_wdata1;
        e.err = (a > 64'd1016) || (a % 8 != 0);
        e.rdata = '0;
        if (e.err) lat = 1;
        else if (i_req_we[e.port]) begin
          lat = 2;
          for (int b = 0; b < 8; b++) ref_mem[int'(a) + b] = d[8 * b +: 8];
        end else begin
          lat = 3;
          for (int b = 0; b < 8; b++) e.rdata[8 * b +: 8] = ref_mem[int'(a) + b];
        end
        if (!e.err) begin
          st_cyc = cyc + 1; st_we = i_req_we[e.port]; st_addr = a; st_wdata = d;
        end
        e.due = cyc + lat;
        exp_q.push_back(e);
        next_free = cyc + lat + 1;
        last_port = e.port;
        acc_total++;
        if (e.port == 0) acc_cnt0++; else acc_cnt1++;
      end
    end
  end

  // Response monitor: every response pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (rd_idx < flush_idx) rd_idx = flush_idx;
      if (rd_idx < exp_q.size() && exp_q[rd_idx].due < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL missing_rsp: got none expected port %0d at cycle %0d", exp_q[rd_idx].port, exp_q[rd_idx].due);
        rd_idx++;
      end
      if (o_rsp_valid != 2'b00) begin
        if (rd_idx >= exp_q.size()) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rsp: got rsp_valid %b expected none (cycle %0d)", o_rsp_valid, cyc);
        end else begin
          e = exp_q[rd_idx];
          rd_idx++;
          $display("rsp port %0d rdata %h err %0d cycle %0d", e.port, o_rsp_rdata, o_rsp_err, cyc);
          chk("rsp_port", 64'(o_rsp_valid), (e.port == 1) ? 64'd2 : 64'd1);
          chk("rsp_rdata", o_rsp_rdata, e.rdata);
          chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic drain(input int bound);
    int t = 0;
    while ((q0.size() > 0 || q1.size() > 0 || i_req_valid != 2'b00 ||
            rd_idx < exp_q.size() || o_busy) && t < bound) begin
      @(posedge i_clk);
      t++;
    end
    chk("drain_timeout", 64'(t >= bound), 64'd0);
    repeat (2) @(posedge i_clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, o_rsp_rdata, 64'd0);
    chk({tag, "_rsp_err"}, 64'(o_rsp_err), 64'd0);
    chk({tag, "_mem_strobes"}, 64'({o_mem_read, o_mem_write}), 64'd0);
    chk({tag, "_mem_addr"}, o_mem_addr, 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, n_fix;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_outputs_zero("reset");
    chk("reset_ready", 64'(o_req_ready), 64'd0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Store then load on the CPU port.
    q0.push_back(mk(1'b1, 64'h10, 64'h1122334455667788));
    q0.push_back(mk(1'b0, 64'h10, 64'h0));
    drain(100);

    // Range, alignment and upper-bit errors, then the last legal word.
    q0.push_back(mk(1'b0, 64'h3F9, 64'h0));
    q0.push_back(mk(1'b0, 64'h0C, 64'h0));
    q0.push_back(mk(1'b1, 64'h8000_0000_0000_0010, 64'hDEAD));
    q1.push_back(mk(1'b1, 64'h3F8, 64'hA5A5_0102_0304_5A5A));
    q1.push_back(mk(1'b0, 64'h3F8, 64'h0));
    drain(100);

    // DMA store with a CPU load to the same word queued behind it.
    q1.push_back(mk(1'b1, 64'h20, 64'hCAFE_F00D_1234_5678));
    @(posedge i_clk);
    q0.push_back(mk(1'b0, 64'h20, 64'h0));
    drain(100);

    // Both ports requesting continuously: grants must alternate.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 64'(i * 8), 64'h0));
      q1.push_back(mk(1'b0, 64'(i * 8 + 64), 64'h0));
    end
    drain(100);

    // Randomized traffic on both ports.
    pct = 70;
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(1) == 0) q0.push_back(rand_item());
      else q1.push_back(rand_item());
    end
    drain(3000);
    pct = 100;

    // Reset during the WAIT cycle of a load abandons it silently.
    q0.push_back(mk(1'b0, 64'h10, 64'h0));
    t = acc_total;
    while (acc_total == t && t < 1000000) begin
      @(posedge i_clk);
      if (cyc > 100000) t = 1000000;
    end
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk_outputs_zero("midreset");
    q0.push_back(mk(1'b0, 64'h10, 64'h0));
    q1.push_back(mk(1'b0, 64'h3F8, 64'h0));
    drain(100);

    // Fixed-priority instance: CPU wins every tie while it keeps requesting.
    @(posedge i_clk);
    #1 f_valid = 2'b11;
    n_fix = 0;
    repeat (24) begin
      @(negedge i_clk);
      if (f_ready != 2'b00) begin
        chk("fix_grant", 64'(f_ready), 64'd1);
        n_fix++;
      end
      if (f_rsp_valid != 2'b00) chk("fix_rsp_port", 64'(f_rsp_valid), 64'd1);
    end
    chk("fix_accept_count", 64'(n_fix), 64'd6);
    @(posedge i_clk);
    #1 f_valid = 2'b10;
    t = 0;
    while (t < 8) begin
      @(negedge i_clk);
      if (f_ready != 2'b00) break;
      t++;
    end
    chk("fix_dma_grant", 64'(f_ready), 64'd2);
    @(posedge i_clk);
    #1 f_valid = 2'b00;
    repeat (6) @(posedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
